// File: rtl/serial_config_loader.sv
`timescale 1ns/1ps
// serial_config_loader
// Turns a serial bit stream into framed configuration words. Each frame is
// DATA_WIDTH payload bits (MSB first) followed by a SYNC_WIDTH marker. A
// SYNC_WORD marker queues the payload in a small show-ahead FIFO. An END_WORD
// marker ends the stream. Words leave on a valid/ready handshake.
// Optional feature macro: CONFIG_CRC_CHECK_EN adds a CRC-16-CCITT trailer check
// (crc_error output) after END_WORD.
module serial_config_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    SYNC_WIDTH = 16,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 16'hFAB2,
    parameter logic [SYNC_WIDTH-1:0] END_WORD   = 16'hFAB3,
    parameter int                    TIMEOUT    = 49,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  restart,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  finished,
    output logic                  overflow,
    output logic [15:0]           word_count
`ifdef CONFIG_CRC_CHECK_EN
    ,
    output logic                  crc_error
`endif
);

    localparam int W  = DATA_WIDTH + SYNC_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
`ifdef CONFIG_CRC_CHECK_EN
        ,
        CRC  = 2'd3
`endif
    } state_t;

    state_t                state, state_nxt;
    logic [W-1:0]          shreg;
    logic [CW-1:0]         bitcnt;
    logic [TW-1:0]         timer;
    logic                  shift_en, push, frame_hit, timer_load, timer_dec;
    logic                  match_sync, match_end;
    logic [DATA_WIDTH-1:0] payload;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr;
    logic [AW:0]           fcount;
    logic                  pop, full, wr_ok, drop;

`ifdef CONFIG_CRC_CHECK_EN
    logic [15:0] crc_calc, crc_rx;
    logic [3:0]  crc_cnt;
    logic        crc_shift, crc_done;

    // CRC-16-CCITT (poly 0x1021), MSB first, over one payload word
    function automatic logic [15:0] crc16_word(input logic [15:0] c,
                                               input logic [DATA_WIDTH-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    // Markers are only recognised on a complete frame of fresh bits
    assign match_sync = (bitcnt == CW'(W)) && (shreg[SYNC_WIDTH-1:0] == SYNC_WORD);
    assign match_end  = (bitcnt == CW'(W)) && (shreg[SYNC_WIDTH-1:0] == END_WORD);
    assign payload    = shreg[W-1:SYNC_WIDTH];
    assign finished   = (state == DONE);

    // State register; restart wins over everything else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      state <= IDLE;
        else if (restart) state <= IDLE;
        else              state <= state_nxt;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt  = state;
        shift_en   = 1'b0;
        push       = 1'b0;
        frame_hit  = 1'b0;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
`ifdef CONFIG_CRC_CHECK_EN
        crc_shift  = 1'b0;
        crc_done   = 1'b0;
`endif
        case (state)
            IDLE, LOAD: begin
                shift_en = bit_valid;
                if (match_sync) begin
                    push       = 1'b1;
                    frame_hit  = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = LOAD;
                end else if (match_end) begin
                    frame_hit = 1'b1;
`ifdef CONFIG_CRC_CHECK_EN
                    state_nxt = CRC;
`else
                    state_nxt = DONE;
`endif
                end else if (state == LOAD && bit_valid) begin
                    timer_dec = 1'b1;
                    if (timer == TW'(1)) state_nxt = DONE;
                end
            end
`ifdef CONFIG_CRC_CHECK_EN
            CRC: begin
                crc_shift = bit_valid;
                if (bit_valid && crc_cnt == 4'd15) begin
                    crc_done  = 1'b1;
                    state_nxt = DONE;
                end
            end
`endif
            default: ;
        endcase
    end

    // Shift register, frame bit counter and inactivity timer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shreg  <= '0;
            bitcnt <= '0;
            timer  <= TW'(TIMEOUT);
        end else if (restart) begin
            shreg  <= '0;
            bitcnt <= '0;
            timer  <= TW'(TIMEOUT);
        end else begin
            if (shift_en) shreg <= {shreg[W-2:0], bit_in};
            if (frame_hit)                           bitcnt <= '0;
            else if (shift_en && bitcnt != CW'(W))   bitcnt <= bitcnt + CW'(1);
            if (timer_load)     timer <= TW'(TIMEOUT);
            else if (timer_dec) timer <= timer - TW'(1);
        end
    end

    assign word_valid = (fcount != '0);
    assign word_data  = word_valid ? mem[rd_ptr] : '0;
    assign pop        = word_valid & word_ready;
    assign full       = (fcount == DEPTH_CNT);
    assign wr_ok      = push && (!full || pop);
    assign drop       = push && full && !pop;

    // FIFO storage: data only, validity is tracked by fcount
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= payload;
    end

    // FIFO pointers, occupancy, overflow flag and pushed-word counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fcount     <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else if (restart) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fcount     <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, pop})
                2'b10:   fcount <= fcount + (AW+1)'(1);
                2'b01:   fcount <= fcount - (AW+1)'(1);
                default: ;
            endcase
            if (drop) overflow <= 1'b1;
            if (wr_ok && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
        end
    end

`ifdef CONFIG_CRC_CHECK_EN
    // Running CRC over queued payloads and capture/compare of the trailer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_calc  <= 16'hFFFF;
            crc_rx    <= '0;
            crc_cnt   <= '0;
            crc_error <= 1'b0;
        end else if (restart) begin
            crc_calc  <= 16'hFFFF;
            crc_rx    <= '0;
            crc_cnt   <= '0;
            crc_error <= 1'b0;
        end else begin
            if (push) crc_calc <= crc16_word(crc_calc, payload);
            if (crc_shift) begin
                crc_rx  <= {crc_rx[14:0], bit_in};
                crc_cnt <= crc_cnt + 4'd1;
            end
            if (crc_done) crc_error <= ({crc_rx[14:0], bit_in} != crc_calc);
        end
    end
`endif

endmodule

// File: tb/tb_serial_config_loader.sv
`timescale 1ns/1ps
// Testbench for serial_config_loader: drives framed bit streams, keeps a
// queue of expected output words and compares each word as it is consumed.
module tb_serial_config_loader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        restart = 1'b0;
    logic        word_ready = 1'b0;
    logic [31:0] word_data;
    logic        word_valid;
    logic        finished;
    logic        overflow;
    logic [15:0] word_count;
`ifdef CONFIG_CRC_CHECK_EN
    logic        crc_error;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    serial_config_loader dut (
        .clk        (clk),
        .resetn     (resetn),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .restart    (restart),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .finished   (finished),
        .overflow   (overflow),
`ifdef CONFIG_CRC_CHECK_EN
        .crc_error  (crc_error),
`endif
        .word_count (word_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer side: every handshake must deliver the oldest expected word
    always @(negedge clk) begin
        if (resetn && !restart && word_valid && word_ready) begin
            if (exp_q.size() == 0) check_eq("sb_unexpected_word", {32'd0, word_data}, 64'h1_0000_0000);
            else                   check_eq("sb_word", {32'd0, word_data}, {32'd0, exp_q.pop_front()});
        end
    end

    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        bit_in    = b;
        bit_valid = 1'b1;
    endtask

    // Lets the last driven bit be sampled, then holds the line idle
    task automatic gap();
        @(posedge clk); #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [31:0] d, input logic [15:0] m);
        logic [47:0] f;
        f = {d, m};
        for (int i = 47; i >= 0; i--) send_bit(f[i]);
        gap();
    endtask

    task automatic pulse_restart();
        @(posedge clk); #1;
        bit_valid = 1'b0;
        restart   = 1'b1;
        @(posedge clk); #1;
        restart   = 1'b0;
        exp_q.delete();
    endtask

`ifdef CONFIG_CRC_CHECK_EN
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [31:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    task automatic crc_run(input logic [15:0] flip, input logic exp_err, input string tag);
        logic [15:0] c;
        pulse_restart();
        word_ready = 1'b1;
        c = crc_model(crc_model(16'hFFFF, 32'h1234_5678), 32'h9ABC_DEF0);
        c = c ^ flip;
        exp_q.push_back(32'h1234_5678);
        send_frame(32'h1234_5678, 16'hFAB2);
        exp_q.push_back(32'h9ABC_DEF0);
        send_frame(32'h9ABC_DEF0, 16'hFAB2);
        send_frame(32'h0, 16'hFAB3);
        for (int i = 15; i >= 0; i--) send_bit(c[i]);
        gap();
        idle(1);
        check_eq({tag, "_crc_error"}, crc_error, exp_err);
        check_eq({tag, "_finished"}, finished, 1'b1);
    endtask
`endif

    initial begin
        logic [31:0] w [6];
        w = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
              32'h4444_0004, 32'h5555_0005, 32'h6666_0006};

        // Reset state
        idle(2);
        check_eq("rst_word_valid", word_valid, 1'b0);
        check_eq("rst_word_data", word_data, 32'h0);
        check_eq("rst_finished", finished, 1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_word_count", word_count, 16'd0);
        resetn = 1'b1;
        idle(2);

        // T1: single word and its latency
        send_frame(32'hDEAD_BEEF, 16'hFAB2);
        check_eq("t1_valid_at_match_edge", word_valid, 1'b0);
        idle(1);
        check_eq("t1_valid", word_valid, 1'b1);
        check_eq("t1_data", word_data, 32'hDEAD_BEEF);
        check_eq("t1_count", word_count, 16'd1);
        check_eq("t1_finished", finished, 1'b0);
        exp_q.push_back(32'hDEAD_BEEF);
        word_ready = 1'b1;
        idle(2);
        check_eq("t1_drained", word_valid, 1'b0);

        // T2: three words then END; END payload and later bits ignored
        pulse_restart();
        exp_q.push_back(32'h0123_4567); send_frame(32'h0123_4567, 16'hFAB2);
        exp_q.push_back(32'h89AB_CDEF); send_frame(32'h89AB_CDEF, 16'hFAB2);
        exp_q.push_back(32'hFFFF_0000); send_frame(32'hFFFF_0000, 16'hFAB2);
        send_frame(32'h0, 16'hFAB3);
        idle(1);
        check_eq("t2_finished", finished, 1'b1);
        check_eq("t2_count", word_count, 16'd3);
        idle(2);
        send_frame(32'hCAFE_F00D, 16'hFAB2);
        idle(2);
        check_eq("t2_after_done_count", word_count, 16'd3);
        check_eq("t2_after_done_valid", word_valid, 1'b0);
        check_eq("t2_queue_drained", exp_q.size(), 0);

        // T3: fill, push+pop while full, then overflow drop
        pulse_restart();
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(w[i]);
            send_frame(w[i], 16'hFAB2);
        end
        idle(1);
        check_eq("t3_full_count", word_count, 16'd4);
        check_eq("t3_full_no_ovf", overflow, 1'b0);
        exp_q.push_back(w[4]);
        send_frame(w[4], 16'hFAB2);
        word_ready = 1'b1;
        idle(1);
        word_ready = 1'b0;
        check_eq("t3_pushpop_ovf", overflow, 1'b0);
        check_eq("t3_pushpop_count", word_count, 16'd5);
        send_frame(w[5], 16'hFAB2);
        idle(1);
        check_eq("t3_ovf", overflow, 1'b1);
        check_eq("t3_drop_count", word_count, 16'd5);
        check_eq("t3_head", word_data, w[1]);
        word_ready = 1'b1;
        idle(6);
        check_eq("t3_drained", word_valid, 1'b0);
        check_eq("t3_queue_drained", exp_q.size(), 0);
        check_eq("t3_ovf_sticky", overflow, 1'b1);

        // T4: marker on bit 48 reloads timer; 49 markerless bits finish
        pulse_restart();
        exp_q.push_back(32'hA5A5_A5A5); send_frame(32'hA5A5_A5A5, 16'hFAB2);
        exp_q.push_back(32'h5A5A_5A5A); send_frame(32'h5A5A_5A5A, 16'hFAB2);
        idle(1);
        check_eq("t4_reload_finished", finished, 1'b0);
        check_eq("t4_count", word_count, 16'd2);
        for (int i = 0; i < 49; i++) send_bit(1'b0);
        check_eq("t4_after48_finished", finished, 1'b0);
        gap();
        check_eq("t4_after49_finished", finished, 1'b1);

        // T5: restart mid-frame with queued words
        pulse_restart();
        word_ready = 1'b0;
        send_frame(w[0], 16'hFAB2);
        send_frame(w[1], 16'hFAB2);
        idle(1);
        check_eq("t5_pre_count", word_count, 16'd2);
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart   = 1'b0;
        bit_valid = 1'b0;
        check_eq("t5_valid", word_valid, 1'b0);
        check_eq("t5_count", word_count, 16'd0);
        check_eq("t5_data", word_data, 32'h0);
        check_eq("t5_finished", finished, 1'b0);
        word_ready = 1'b1;
        exp_q.push_back(32'hBEEF_0123);
        send_frame(32'hBEEF_0123, 16'hFAB2);
        idle(1);
        check_eq("t5_fresh_count", word_count, 16'd1);
        idle(2);
        check_eq("t5_queue_drained", exp_q.size(), 0);

`ifdef CONFIG_CRC_CHECK_EN
        // T6: CRC trailer good and corrupted
        crc_run(16'h0000, 1'b0, "t6_good");
        crc_run(16'h0100, 1'b1, "t6_bad");
`endif

        idle(3);
        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
